// File: rtl/response_transmitter_pkg.sv
// response_transmitter_pkg: transmitter FSM encoding and shared UART defaults
package response_transmitter_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int DEFAULT_BAUD_RATE = 115200;
  localparam int DEFAULT_FIFO_DEPTH = 16;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: single-clock byte buffer with registered full/empty and sticky overflow
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("byte_fifo DEPTH must be a power of two >= 2");
  end
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_n;
  logic accept;
  // a pop in the same cycle frees the slot a full-buffer write needs
  assign accept = push && (!full || pop);
  assign count_n = count + (AW+1)'(accept) - (AW+1)'(pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (reset && accept) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full <= count_n == (AW+1)'(DEPTH);
      empty <= count_n == '0;
      if (push && !accept) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/response_transmitter.sv
// response_transmitter: buffered 8N1 UART transmitter for interpreter responses
module response_transmitter
  import response_transmitter_pkg::*;
#(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD_RATE = DEFAULT_BAUD_RATE,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write_uart,
  input  logic [7:0] uart_out,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BW = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("CLK_FREQ/BAUD_RATE must be at least 2");
  end
  tx_state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n, head;
  logic tx_n, pop, bit_end;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(write_uart),
    .pop(pop),
    .din(uart_out),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .overflow(overflow)
  );
  assign busy = state != IDLE;
  assign bit_end = baud == LAST;
  always_comb begin
    state_n = state;
    baud_n = bit_end ? '0 : baud + BW'(1);
    bit_n = bit_cnt;
    shift_n = shift;
    tx_n = tx;
    pop = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!fifo_empty) begin
          pop = 1'b1;
          shift_n = head;
          tx_n = 1'b0;
          state_n = START;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_n = '0;
        tx_n = shift[0];
      end
      DATA: if (bit_end) begin
        // tx is preloaded with the next bit so the line changes on the bit boundary
        if (bit_cnt == 3'd7) begin
          state_n = STOP;
          tx_n = 1'b1;
        end else begin
          bit_n = bit_cnt + 3'd1;
          shift_n = shift >> 1;
          tx_n = shift[1];
        end
      end
      STOP: if (bit_end) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      tx <= tx_n;
    end
  end
endmodule

// File: tb/tb_response_transmitter.sv
// tb_response_transmitter: directed checks of framing, buffering, overflow and reset
module tb_response_transmitter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic write_uart = 1'b0;
  logic [7:0] uart_out = 8'h00;
  logic tx, busy, fifo_full, fifo_empty, overflow;
  int checks = 0;
  int errors = 0;
  response_transmitter #(
    .CLK_FREQ(1000000),
    .BAUD_RATE(100000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .write_uart(write_uart),
    .uart_out(uart_out),
    .tx(tx),
    .busy(busy),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask
  // k counts cycles since the frame's START edge: 0-9 start, 10-89 data LSB first, 90-99 stop
  task automatic frame(input logic [7:0] b, input int from, input int to);
    for (int k = from; k <= to; k++) begin
      logic e;
      e = k < 10 ? 1'b0 : k >= 90 ? 1'b1 : b[k/10-1];
      chk($sformatf("tx frame %h k%0d", b, k), tx, e);
      chk($sformatf("busy frame %h k%0d", b, k), busy, 1'b1);
      step();
    end
  endtask
  task automatic idle_gap(input string tag);
    chk({tag, " gap tx"}, tx, 1'b1);
    chk({tag, " gap busy"}, busy, 1'b0);
    step();
  endtask
  task automatic check_reset_state(input string tag);
    chk({tag, " tx"}, tx, 1'b1);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " empty"}, fifo_empty, 1'b1);
    chk({tag, " full"}, fifo_full, 1'b0);
    chk({tag, " overflow"}, overflow, 1'b0);
  endtask
  initial begin
    step(2);
    check_reset_state("reset");
    reset = 1'b1;
    step();
    // single byte A5
    write_uart = 1'b1;
    uart_out = 8'hA5;
    step();
    write_uart = 1'b0;
    uart_out = 8'hFF;
    chk("a5 empty after push", fifo_empty, 1'b0);
    chk("a5 tx before start", tx, 1'b1);
    chk("a5 busy before start", busy, 1'b0);
    step();
    chk("a5 empty after pop", fifo_empty, 1'b1);
    frame(8'hA5, 0, 99);
    chk("a5 busy after stop", busy, 1'b0);
    chk("a5 tx after stop", tx, 1'b1);
    step(3);
    // three back-to-back bytes
    write_uart = 1'b1;
    uart_out = 8'h00;
    step();
    uart_out = 8'hFF;
    step();
    uart_out = 8'h3C;
    step();
    write_uart = 1'b0;
    frame(8'h00, 1, 99);
    idle_gap("b2b 1");
    frame(8'hFF, 0, 99);
    idle_gap("b2b 2");
    frame(8'h3C, 0, 99);
    chk("b2b final busy", busy, 1'b0);
    chk("b2b final empty", fifo_empty, 1'b1);
    step(3);
    // six writes into a depth-4 buffer
    write_uart = 1'b1;
    uart_out = 8'h11;
    step();
    uart_out = 8'h22;
    step();
    uart_out = 8'h33;
    step();
    uart_out = 8'h44;
    step();
    uart_out = 8'h55;
    step();
    chk("ovf full before sixth", fifo_full, 1'b1);
    chk("ovf clear before sixth", overflow, 1'b0);
    uart_out = 8'h66;
    step();
    write_uart = 1'b0;
    chk("ovf full after sixth", fifo_full, 1'b1);
    chk("ovf set", overflow, 1'b1);
    frame(8'h11, 4, 99);
    idle_gap("ovf 1");
    chk("ovf full drops after pop", fifo_full, 1'b0);
    frame(8'h22, 0, 99);
    idle_gap("ovf 2");
    frame(8'h33, 0, 99);
    idle_gap("ovf 3");
    frame(8'h44, 0, 99);
    idle_gap("ovf 4");
    frame(8'h55, 0, 99);
    chk("ovf empty after five", fifo_empty, 1'b1);
    chk("ovf sticky", overflow, 1'b1);
    step(30);
    chk("ovf no sixth frame tx", tx, 1'b1);
    chk("ovf no sixth frame busy", busy, 1'b0);
    // write coinciding with the IDLE pop while full
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_reset_state("rst2");
    write_uart = 1'b1;
    uart_out = 8'hA1;
    step();
    uart_out = 8'hB2;
    step();
    uart_out = 8'hC3;
    step();
    uart_out = 8'hD4;
    step();
    uart_out = 8'hE5;
    step();
    write_uart = 1'b0;
    frame(8'hA1, 3, 99);
    chk("pop+push full before", fifo_full, 1'b1);
    chk("pop+push idle", busy, 1'b0);
    write_uart = 1'b1;
    uart_out = 8'hF6;
    step();
    write_uart = 1'b0;
    chk("pop+push full kept", fifo_full, 1'b1);
    chk("pop+push no overflow", overflow, 1'b0);
    frame(8'hB2, 0, 99);
    idle_gap("pp 1");
    frame(8'hC3, 0, 99);
    idle_gap("pp 2");
    frame(8'hD4, 0, 99);
    idle_gap("pp 3");
    frame(8'hE5, 0, 99);
    idle_gap("pp 4");
    frame(8'hF6, 0, 99);
    chk("pp empty", fifo_empty, 1'b1);
    chk("pp overflow", overflow, 1'b0);
    step(2);
    // reset during data bit 4 with two bytes queued
    write_uart = 1'b1;
    uart_out = 8'h01;
    step();
    uart_out = 8'h02;
    step();
    uart_out = 8'h03;
    step();
    write_uart = 1'b0;
    chk("mid queued", fifo_empty, 1'b0);
    frame(8'h01, 1, 54);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_reset_state("mid abort");
    for (int i = 0; i < 250; i++) begin
      chk($sformatf("mid quiet tx %0d", i), tx, 1'b1);
      step();
    end
    chk("mid quiet busy", busy, 1'b0);
    write_uart = 1'b1;
    uart_out = 8'h5A;
    step();
    write_uart = 1'b0;
    step();
    frame(8'h5A, 0, 99);
    chk("after abort frame busy", busy, 1'b0);
    // write in the same cycle as reset
    reset = 1'b0;
    write_uart = 1'b1;
    uart_out = 8'h55;
    step();
    reset = 1'b1;
    write_uart = 1'b0;
    check_reset_state("rst write");
    step();
    chk("rst write empty", fifo_empty, 1'b1);
    for (int i = 0; i < 30; i++) begin
      chk($sformatf("rst write tx %0d", i), tx, 1'b1);
      step();
    end
    chk("rst write busy", busy, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/response_transmitter.md
RESPONSE_TRANSMITTER -- requirements
Module: response_transmitter

Interface
REQ-001 Parameter CLK_FREQ, default 25000000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 16, byte buffer entries; power of two, >= 2.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 write_uart  input  1  one-cycle byte-write strobe from the command interpreter.
REQ-007 uart_out  input  8  byte to send; sampled when write_uart=1.
REQ-008 tx  output  1  serial line, 8N1, idle high.
REQ-009 busy  output  1  high while a frame is on the line (START, DATA or STOP state).
REQ-010 fifo_full  output  1  buffer holds FIFO_DEPTH bytes.
REQ-011 fifo_empty  output  1  buffer holds no bytes.
REQ-012 overflow  output  1  sticky; a write was dropped.

Function
REQ-013 CLKS_PER_BIT SHALL be CLK_FREQ/BAUD_RATE, integer-truncated; elaboration SHALL fail if the result is < 2.
REQ-014 A byte SHALL be enqueued when write_uart=1 and (fifo_full=0, or a pop occurs in the same cycle).
REQ-015 When write_uart=1, fifo_full=1 and no pop occurs in that cycle, the byte SHALL be dropped, overflow SHALL set, and FIFO contents SHALL be unchanged.
REQ-016 fifo_full and fifo_empty SHALL be registered and SHALL reflect occupancy after the current edge's push/pop.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with an extra pointer bit or counter, so full and empty are unambiguous.
REQ-018 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 In IDLE with fifo_empty=0, the FSM SHALL pop the head byte into a shift register and enter START on the same edge.
REQ-020 A write into an empty FIFO at edge N SHALL drive fifo_empty low after edge N, and tx SHALL go low after edge N+1.
REQ-021 In START, tx SHALL be 0 for CLKS_PER_BIT cycles, then the FSM SHALL enter DATA.
REQ-022 In DATA, tx SHALL output shift-register bits LSB first, CLKS_PER_BIT cycles each, for 8 bits, then the FSM SHALL enter STOP.
REQ-023 In STOP, tx SHALL be 1 for CLKS_PER_BIT cycles, then the FSM SHALL enter IDLE.
REQ-024 Back-to-back frames SHALL have no gap beyond one IDLE cycle; the frame period SHALL be 10*CLKS_PER_BIT+1 cycles.
REQ-025 tx SHALL be driven from a register (glitch-free).
REQ-026 The bit counter SHALL be 3 bits; the baud counter SHALL be wide enough for CLKS_PER_BIT-1.
REQ-027 busy SHALL be 1 exactly when the state is not IDLE.
REQ-028 uart_out SHALL be ignored when write_uart=0.

Reset
REQ-029 On reset=0 at a rising edge: state=IDLE, tx=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0, pointers and counters=0.
REQ-030 Reset mid-frame SHALL abort the frame, take tx high after that edge, and discard all buffered bytes.
REQ-031 A write_uart asserted in the same cycle as reset=0 SHALL be ignored.
REQ-032 overflow SHALL clear only on reset.

Structure
REQ-033 The FSM state encoding and the BAUD_RATE/FIFO_DEPTH defaults SHALL live in a shared package used by both the interpreter and the transmitter.
REQ-034 The buffer SHALL be a sub-module byte_fifo (synchronous, single clock, registered flags), instantiated once.
REQ-035 Baud timing, shift register and FSM SHALL reside in response_transmitter.

Verification (CLK_FREQ=1000000, BAUD_RATE=100000, so CLKS_PER_BIT=10; FIFO_DEPTH=4)
REQ-036 Single write 0xA5 into an idle FIFO -> tx low 2 cycles after the strobe; bits 1,0,1,0,0,1,0,1 at 10 cycles each; stop high 10 cycles; busy high for 100 cycles.
REQ-037 Write 0x00, 0xFF, 0x3C on consecutive cycles -> three frames in order, each 101 cycles apart, with no corruption.
REQ-038 Six consecutive writes while idle -> first byte popped; next four buffered; fifo_full=1; sixth write dropped; overflow=1; exactly five frames sent.
REQ-039 fifo_full=1 with write_uart coinciding with the IDLE pop -> byte accepted, overflow stays 0, fifo_full remains 1.
REQ-040 reset=0 during bit 4 of a frame with 2 bytes queued -> tx=1, busy=0 and fifo_empty=1 after that edge; no further frames until a new write.
REQ-041 Write 0x55 at the same edge as reset=0 -> the byte is not sent and fifo_empty stays 1.
